sw_array_ctrl: RTL and testbench
================================

# sw_array_ctrl

Job controller for the Smith-Waterman systolic array of processing elements. It accepts an alignment job (target length), clears the array, and streams target bases into the first processing element while holding that element's left-neighbour inputs at the biased zero. It then waits for the last element's valid flag, un-biases that element's highest score, and returns the score over a valid/ready handshake. It sits between the target-base FIFO and PE[0], and also taps PE[N_PE-1].

## Interface
- SCORE_WIDTH, 12: score bus width; must match the processing elements.
- N_PE, 16: number of processing elements in the chain; sets the watchdog limit.
- LEN_WIDTH, 10: width of the target-length field.
- clk  in  1  clock; every register updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  job request; sampled only in IDLE.
- target_len  in  LEN_WIDTH  number of target bases; sampled together with start.
- busy  out  1  high in every state except IDLE.
- tgt_valid  in  1  FIFO has a base.
- tgt_base  in  2  base encoding: A=00, G=01, T=10, C=11.
- tgt_ready  out  1  controller accepts a base this cycle.
- pe_rst  out  1  active-low synchronous clear to the array.
- pe_en  out  1  drives PE[0].en_in.
- pe_data  out  2  drives PE[0].data_in.
- pe_M, pe_I, pe_High  out  SCORE_WIDTH  drive PE[0] left inputs; constant ZERO = 2^(SCORE_WIDTH-1).
- last_high  in  SCORE_WIDTH  PE[N_PE-1].High_out.
- last_vld  in  1  PE[N_PE-1].vld.
- score  out  SCORE_WIDTH-1  un-biased alignment score.
- err  out  1  job aborted; qualified by score_valid.
- score_valid  out  1  result available.
- score_ready  in  1  result consumed.

## Operation
- States: IDLE, CLEAR, STREAM, DRAIN, RESULT.
- IDLE → CLEAR: on start=1 with target_len≠0. The controller latches target_len into a remaining-base counter.
- IDLE → RESULT: on start=1 with target_len=0. score=0, err=0.
- CLEAR: lasts one cycle. pe_rst=0, then the FSM moves to STREAM.
- STREAM: tgt_ready=1.
  - On each tgt_valid & tgt_ready, the counter decrements.
  - When the counter reaches 0 on a handshake, the FSM moves to DRAIN.
- Underflow: in STREAM, a cycle with tgt_valid=0 while the counter is non-zero sets err and moves the FSM to DRAIN. The array cannot stall, so the job is truncated.
- DRAIN: tgt_ready=0, pe_en=0.
  - On last_vld=1: capture last_high and move to RESULT.
  - score = last_high − ZERO. If last_high < ZERO, score saturates to 0.
- RESULT: score_valid=1; score and err are held stable. On score_ready=1, the FSM moves to IDLE.
- start outside IDLE is ignored. A start in the same cycle as the RESULT→IDLE transition is ignored; it is accepted the following cycle.
- pe_M, pe_I and pe_High are the constant ZERO in all states, including reset.

## Timing
- All outputs are registered except tgt_ready. tgt_ready is decoded from the state, so that combinational path stays inside the controller.
- Reset values:
  - State IDLE; busy=0, tgt_ready=0.
  - pe_rst=0, so the array is held in clear. It is released (1) on the first clock after rst deasserts.
  - pe_en=0, pe_data=00, score=0, err=0, score_valid=0.
- Base handshake in cycle t produces pe_en=1 and pe_data=tgt_base in cycle t+1. Consecutive handshakes keep pe_en continuously high.
- pe_en falls in the cycle after the last handshake, or after the underflow cycle.
- last_vld is expected about N_PE cycles after pe_en falls.
- Job latency for L bases with no underflow: 1 cycle (CLEAR) + L + drain + 1 cycle to score_valid.
- Asynchronous reset mid-job: the FSM returns immediately to IDLE with all reset values. Any partial result is discarded.

## Configuration
- SW_CTRL_WATCHDOG_EN defined:
  - DRAIN has a cycle counter. If last_vld has not arrived after 2*N_PE+4 cycles, the FSM enters RESULT with err=1 and score=0.
- SW_CTRL_WATCHDOG_EN undefined: DRAIN waits indefinitely for last_vld. err is set only by underflow.

## Test plan
- Basic job: N_PE=4, query ACGT loaded; target ACGT streamed continuously, match=+2, mismatch=−1, gap_open=−2, gap_extend=−1 (ZERO-biased). Required: score=8, err=0, one base accepted per cycle, pe_en high for exactly 4 cycles.
- Zero length: start with target_len=0. Required: score_valid=1 two cycles later, score=0, tgt_ready never asserted.
- Underflow: target_len=6, tgt_valid dropped after 3 bases. Required: pe_en falls after 3 cycles, err=1 with score_valid, FSM returns to IDLE after score_ready.
- Backpressure on result: hold score_ready=0 for 10 cycles. Required: score, err and score_valid stay stable; start pulses are ignored; IDLE is entered the cycle after score_ready=1.
- Watchdog (macro defined): last_vld forced low. Required: err=1 and score=0 exactly 2*N_PE+4 cycles after entering DRAIN. With the macro undefined, busy stays high.
- Reset mid-STREAM: rst=0 during base 3. Required: immediate IDLE, pe_rst=0, pe_en=0, score_valid=0. A new job then completes correctly.

Source files
------------

// File: rtl/sw_array_ctrl.sv
// Smith-Waterman array job controller: clears the PE chain, streams target bases into PE[0], returns the un-biased score.
// Latency 1 + L + drain + 1 cycles to score_valid; result held under score_ready backpressure; SW_CTRL_WATCHDOG_EN bounds DRAIN.
module sw_array_ctrl #(
    parameter int SCORE_WIDTH = 12,
    parameter int N_PE        = 16,
    parameter int LEN_WIDTH   = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [LEN_WIDTH-1:0]   target_len,
    output logic                   busy,
    input  logic                   tgt_valid,
    input  logic [1:0]             tgt_base,
    output logic                   tgt_ready,
    output logic                   pe_rst,
    output logic                   pe_en,
    output logic [1:0]             pe_data,
    output logic [SCORE_WIDTH-1:0] pe_M,
    output logic [SCORE_WIDTH-1:0] pe_I,
    output logic [SCORE_WIDTH-1:0] pe_High,
    input  logic [SCORE_WIDTH-1:0] last_high,
    input  logic                   last_vld,
    output logic [SCORE_WIDTH-2:0] score,
    output logic                   err,
    output logic                   score_valid,
    input  logic                   score_ready
);

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, RESULT} state_t;

    localparam logic [SCORE_WIDTH-1:0] ZERO = {1'b1, {(SCORE_WIDTH-1){1'b0}}};

    if (N_PE < 1 || SCORE_WIDTH < 2 || LEN_WIDTH < 1) begin : g_bad_params
        $error("sw_array_ctrl: N_PE, SCORE_WIDTH and LEN_WIDTH out of range");
    end

    state_t                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic                   pe_rst_q, pe_rst_d;
    logic                   pe_en_q, pe_en_d;
    logic [1:0]             pe_data_q, pe_data_d;
    logic [SCORE_WIDTH-2:0] score_q, score_d;
    logic                   err_q, err_d;
    logic                   score_valid_q, score_valid_d;
    logic                   hs;
    logic                   wd_expired;
    logic [SCORE_WIDTH-2:0] unbiased;

    // Decoded straight from the state so the FIFO sees no path through our inputs.
    assign tgt_ready = (state_q == STREAM);
    assign hs        = tgt_valid & tgt_ready;
    assign unbiased  = last_high[SCORE_WIDTH-1] ? last_high[SCORE_WIDTH-2:0] : '0;

`ifdef SW_CTRL_WATCHDOG_EN
    localparam int WD_LIMIT = 2 * N_PE + 4;
    localparam int WD_W     = $clog2(WD_LIMIT + 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

    always_comb begin
        wd_cnt_d = '0;
        if (state_q == DRAIN) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
    end

    // Fires on the last permitted DRAIN cycle so RESULT starts exactly WD_LIMIT cycles after DRAIN entry.
    assign wd_expired = (wd_cnt_q == WD_W'(WD_LIMIT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`else
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        score_d = score_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    score_d = '0;
                    err_d   = 1'b0;
                    if (target_len != '0) begin
                        cnt_d   = target_len;
                        state_d = CLEAR;
                    end else begin
                        state_d = RESULT;
                    end
                end
            end
            CLEAR: state_d = STREAM;
            STREAM: begin
                // The array cannot stall, so a missing base truncates the job.
                if (tgt_valid) begin
                    cnt_d = cnt_q - LEN_WIDTH'(1);
                    if (cnt_q == LEN_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end else begin
                    err_d   = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_vld) begin
                    score_d = unbiased;
                    state_d = RESULT;
                end else if (wd_expired) begin
                    score_d = '0;
                    err_d   = 1'b1;
                    state_d = RESULT;
                end
            end
            RESULT: begin
                if (score_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d        = (state_d != IDLE);
        pe_rst_d      = (state_d != CLEAR);
        pe_en_d       = hs;
        pe_data_d     = hs ? tgt_base : pe_data_q;
        score_valid_d = (state_d == RESULT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            busy_q        <= 1'b0;
            pe_rst_q      <= 1'b0;
            pe_en_q       <= 1'b0;
            pe_data_q     <= 2'b00;
            score_q       <= '0;
            err_q         <= 1'b0;
            score_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            busy_q        <= busy_d;
            pe_rst_q      <= pe_rst_d;
            pe_en_q       <= pe_en_d;
            pe_data_q     <= pe_data_d;
            score_q       <= score_d;
            err_q         <= err_d;
            score_valid_q <= score_valid_d;
        end
    end

    assign busy        = busy_q;
    assign pe_rst      = pe_rst_q;
    assign pe_en       = pe_en_q;
    assign pe_data     = pe_data_q;
    assign score       = score_q;
    assign err         = err_q;
    assign score_valid = score_valid_q;
    assign pe_M        = ZERO;
    assign pe_I        = ZERO;
    assign pe_High     = ZERO;

endmodule

// File: tb/tb_sw_array_ctrl.sv
// Directed bench for sw_array_ctrl with N_PE=4; PE[N_PE-1] is emulated by a timed last_vld pulse.
module tb_sw_array_ctrl;

    localparam int SW  = 12;
    localparam int NPE = 4;
    localparam int LW  = 10;
    localparam logic [SW-1:0] ZERO = 12'd2048;

    logic          clk;
    logic          rst;
    logic          start;
    logic [LW-1:0] target_len;
    logic          busy;
    logic          tgt_valid;
    logic [1:0]    tgt_base;
    logic          tgt_ready;
    logic          pe_rst;
    logic          pe_en;
    logic [1:0]    pe_data;
    logic [SW-1:0] pe_M;
    logic [SW-1:0] pe_I;
    logic [SW-1:0] pe_High;
    logic [SW-1:0] last_high;
    logic          last_vld;
    logic [SW-2:0] score;
    logic          err;
    logic          score_valid;
    logic          score_ready;

    int errors;
    int checks;

    sw_array_ctrl #(.SCORE_WIDTH(SW), .N_PE(NPE), .LEN_WIDTH(LW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .target_len  (target_len),
        .busy        (busy),
        .tgt_valid   (tgt_valid),
        .tgt_base    (tgt_base),
        .tgt_ready   (tgt_ready),
        .pe_rst      (pe_rst),
        .pe_en       (pe_en),
        .pe_data     (pe_data),
        .pe_M        (pe_M),
        .pe_I        (pe_I),
        .pe_High     (pe_High),
        .last_high   (last_high),
        .last_vld    (last_vld),
        .score       (score),
        .err         (err),
        .score_valid (score_valid),
        .score_ready (score_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Emulates the tail PE: result appears N_PE cycles later, then one more edge lands RESULT.
    task automatic pe_tail(input logic [SW-1:0] hi);
        repeat (NPE) tick;
        last_high = hi;
        last_vld  = 1'b1;
        tick;
        last_vld  = 1'b0;
        last_high = '0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #12;
        checks++;
        if ({busy, tgt_ready, pe_rst, pe_en, pe_data, err, score_valid} !== 8'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000000",
                     {busy, tgt_ready, pe_rst, pe_en, pe_data, err, score_valid});
        end
        checks++;
        if (score !== 11'd0) begin
            errors++;
            $display("FAIL reset_score: got %0d expected 0", score);
        end
        checks++;
        if (pe_M !== ZERO || pe_I !== ZERO || pe_High !== ZERO) begin
            errors++;
            $display("FAIL reset_zero_bias: got %0d/%0d/%0d expected 2048", pe_M, pe_I, pe_High);
        end
        @(negedge clk);
        rst = 1'b1;
        tick;
        checks++;
        if (pe_rst !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got pe_rst=%b busy=%b expected pe_rst=1 busy=0", pe_rst, busy);
        end
    endtask

    task automatic test_basic;
        logic [1:0] bases [4];
        bases[0] = 2'b00; bases[1] = 2'b11; bases[2] = 2'b01; bases[3] = 2'b10;
        start = 1'b1; target_len = 10'd4;
        tick;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || pe_rst !== 1'b0 || tgt_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_clear: got busy=%b pe_rst=%b tgt_ready=%b expected 1 0 0", busy, pe_rst, tgt_ready);
        end
        tgt_valid = 1'b1; tgt_base = bases[0];
        tick;
        checks++;
        if (pe_rst !== 1'b1 || pe_en !== 1'b0) begin
            errors++;
            $display("FAIL basic_stream_entry: got pe_rst=%b pe_en=%b expected 1 0", pe_rst, pe_en);
        end
        for (int i = 0; i < 4; i++) begin
            tgt_base = bases[i];
            checks++;
            if (tgt_ready !== 1'b1) begin
                errors++;
                $display("FAIL basic_ready_%0d: got %b expected 1", i, tgt_ready);
            end
            tick;
            checks++;
            if (pe_en !== 1'b1 || pe_data !== bases[i]) begin
                errors++;
                $display("FAIL basic_base_%0d: got en=%b data=%b expected en=1 data=%b", i, pe_en, pe_data, bases[i]);
            end
        end
        tgt_valid = 1'b0;
        checks++;
        if (tgt_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain_ready: got %b expected 0", tgt_ready);
        end
        tick;
        checks++;
        if (pe_en !== 1'b0) begin
            errors++;
            $display("FAIL basic_en_fall: got %b expected 0", pe_en);
        end
        pe_tail(12'd2056);
        checks++;
        if (score_valid !== 1'b1 || score !== 11'd8 || err !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got vld=%b score=%0d err=%b expected 1 8 0", score_valid, score, err);
        end
        score_ready = 1'b1;
        tick;
        score_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || score_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: got busy=%b vld=%b expected 0 0", busy, score_valid);
        end
    endtask

    task automatic test_zero_len;
        start = 1'b1; target_len = 10'd0;
        checks++;
        if (score_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_pre: got vld=%b expected 0", score_valid);
        end
        tick;
        start = 1'b0;
        checks++;
        if (tgt_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_ready_a: got %b expected 0", tgt_ready);
        end
        tick;
        checks++;
        if (score_valid !== 1'b1 || score !== 11'd0 || err !== 1'b0 || tgt_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_result: got vld=%b score=%0d err=%b rdy=%b expected 1 0 0 0",
                     score_valid, score, err, tgt_ready);
        end
        score_ready = 1'b1;
        tick;
        score_ready = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_underflow;
        start = 1'b1; target_len = 10'd6;
        tick;
        start = 1'b0;
        tgt_valid = 1'b1; tgt_base = 2'b01;
        tick;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if (pe_en !== 1'b1) begin
                errors++;
                $display("FAIL under_en_%0d: got %b expected 1", i, pe_en);
            end
        end
        tgt_valid = 1'b0;
        tick;
        checks++;
        if (pe_en !== 1'b0 || tgt_ready !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL under_trunc: got en=%b rdy=%b err=%b expected 0 0 1", pe_en, tgt_ready, err);
        end
        pe_tail(12'd2051);
        checks++;
        if (score_valid !== 1'b1 || err !== 1'b1 || score !== 11'd3) begin
            errors++;
            $display("FAIL under_result: got vld=%b err=%b score=%0d expected 1 1 3", score_valid, err, score);
        end
        score_ready = 1'b1;
        tick;
        score_ready = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL under_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_backpressure;
        start = 1'b1; target_len = 10'd1;
        tick;
        start = 1'b0;
        tgt_valid = 1'b1; tgt_base = 2'b11;
        tick;
        tick;
        tgt_valid = 1'b0;
        pe_tail(12'hFFF);
        for (int i = 0; i < 10; i++) begin
            start      = i[0];
            target_len = 10'd0;
            last_high  = 12'd0;
            last_vld   = 1'b1;
            tick;
            checks++;
            if (score_valid !== 1'b1 || score !== 11'd2047 || err !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold_%0d: got vld=%b score=%0d err=%b busy=%b expected 1 2047 0 1",
                         i, score_valid, score, err, busy);
            end
        end
        last_vld = 1'b0;
        start = 1'b1; target_len = 10'd0; score_ready = 1'b1;
        tick;
        checks++;
        if (busy !== 1'b0 || score_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got busy=%b vld=%b expected 0 0", busy, score_valid);
        end
        tick;
        checks++;
        if (busy !== 1'b1 || score_valid !== 1'b1 || score !== 11'd0) begin
            errors++;
            $display("FAIL bp_next_start: got busy=%b vld=%b score=%0d expected 1 1 0", busy, score_valid, score);
        end
        start = 1'b0;
        tick;
        score_ready = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_final_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_saturate;
        start = 1'b1; target_len = 10'd1;
        tick;
        start = 1'b0;
        tgt_valid = 1'b1; tgt_base = 2'b10;
        tick;
        tick;
        tgt_valid = 1'b0;
        pe_tail(12'd2047);
        checks++;
        if (score_valid !== 1'b1 || score !== 11'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL saturate: got vld=%b score=%0d err=%b expected 1 0 0", score_valid, score, err);
        end
        score_ready = 1'b1;
        tick;
        score_ready = 1'b0;
    endtask

    task automatic test_watchdog;
        start = 1'b1; target_len = 10'd1;
        tick;
        start = 1'b0;
        tgt_valid = 1'b1; tgt_base = 2'b00;
        tick;
        tick;
        tgt_valid = 1'b0;
`ifdef SW_CTRL_WATCHDOG_EN
        begin
            logic early;
            early = 1'b0;
            for (int k = 1; k < 2 * NPE + 4; k++) begin
                tick;
                if (score_valid !== 1'b0) early = 1'b1;
            end
            checks++;
            if (early !== 1'b0) begin
                errors++;
                $display("FAIL wd_early: got early=%b expected 0", early);
            end
            tick;
            checks++;
            if (score_valid !== 1'b1 || err !== 1'b1 || score !== 11'd0) begin
                errors++;
                $display("FAIL wd_fire: got vld=%b err=%b score=%0d expected 1 1 0", score_valid, err, score);
            end
        end
`else
        repeat (2 * NPE + 10) tick;
        checks++;
        if (busy !== 1'b1 || score_valid !== 1'b0) begin
            errors++;
            $display("FAIL wd_wait: got busy=%b vld=%b expected 1 0", busy, score_valid);
        end
        pe_tail(12'd2049);
        checks++;
        if (score_valid !== 1'b1 || score !== 11'd1 || err !== 1'b0) begin
            errors++;
            $display("FAIL wd_late_result: got vld=%b score=%0d err=%b expected 1 1 0", score_valid, score, err);
        end
`endif
        score_ready = 1'b1;
        tick;
        score_ready = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wd_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid;
        start = 1'b1; target_len = 10'd6;
        tick;
        start = 1'b0;
        tgt_valid = 1'b1; tgt_base = 2'b01;
        tick;
        tick;
        tick;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, tgt_ready, pe_rst, pe_en, score_valid} !== 5'b0) begin
            errors++;
            $display("FAIL rstmid_async: got %b expected 00000", {busy, tgt_ready, pe_rst, pe_en, score_valid});
        end
        #2;
        rst = 1'b1;
        tgt_valid = 1'b0;
        tick;
        checks++;
        if (pe_rst !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_release: got pe_rst=%b busy=%b expected 1 0", pe_rst, busy);
        end
        start = 1'b1; target_len = 10'd2;
        tick;
        start = 1'b0;
        tgt_valid = 1'b1; tgt_base = 2'b10;
        tick;
        tick;
        tgt_base = 2'b00;
        checks++;
        if (pe_en !== 1'b1 || pe_data !== 2'b10) begin
            errors++;
            $display("FAIL rstmid_base0: got en=%b data=%b expected 1 10", pe_en, pe_data);
        end
        tick;
        tgt_valid = 1'b0;
        checks++;
        if (pe_en !== 1'b1 || pe_data !== 2'b00 || tgt_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_base1: got en=%b data=%b rdy=%b expected 1 00 0", pe_en, pe_data, tgt_ready);
        end
        pe_tail(12'd2053);
        checks++;
        if (score_valid !== 1'b1 || score !== 11'd5 || err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_result: got vld=%b score=%0d err=%b expected 1 5 0", score_valid, score, err);
        end
        score_ready = 1'b1;
        tick;
        score_ready = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_idle: got busy=%b expected 0", busy);
        end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        rst         = 1'b0;
        start       = 1'b0;
        target_len  = '0;
        tgt_valid   = 1'b0;
        tgt_base    = 2'b00;
        last_high   = '0;
        last_vld    = 1'b0;
        score_ready = 1'b0;

        test_reset;
        test_basic;
        test_zero_len;
        test_underflow;
        test_backpressure;
        test_saturate;
        test_watchdog;
        test_reset_mid;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
